// File: rtl/lsu_port.sv
// Load/store port: bridges a one-request-at-a-time pipeline handshake to a
// registered-read data memory. Optional macro LSU_ALIGN_CHECK_EN rejects misaligned accesses.
module lsu_port #(
    parameter int N = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        memRW_o,
    output logic [1:0]  dataSec_o,
    output logic [31:0] addr_o,
    output logic [31:0] dataW_o,
    input  logic [31:0] data_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t      state_q, state_d;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic        resp_q, err_q, err_d;
    logic        accept, legal_f3, oob, misal, bad;
    logic [32:0] nbytes, last;

    assign accept = req_valid_i && (state_q == IDLE);

    always_comb begin
        if (is_store_i)
            legal_f3 = !funct3_i[2] && (funct3_i[1:0] != 2'b11);
        else
            legal_f3 = (funct3_i[1:0] != 2'b11) && !(funct3_i[2] && funct3_i[1]);
        case (funct3_i[1:0])
            2'b00:   nbytes = 33'd1;
            2'b01:   nbytes = 33'd2;
            default: nbytes = 33'd4;
        endcase
        // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back in range
        last = {1'b0, addr_i} + nbytes - 33'd1;
        oob  = last > 33'(N);
`ifdef LSU_ALIGN_CHECK_EN
        misal = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        bad = !legal_f3 || oob || misal;
    end

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'd0, d[7:0]};
            3'b101:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (accept) begin
                if (bad) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: if (store_q) begin
                state_d = RESP;
                err_d   = 1'b0;
                rdata_d = '0;
            end else begin
                state_d = CAPT;
            end
            CAPT: begin
                state_d = RESP;
                err_d   = 1'b0;
                rdata_d = extend(f3_q, data_i);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            resp_q  <= (state_d == RESP);
            if (accept) begin
                store_q <= is_store_i;
                f3_q    <= funct3_i;
            end
            // memory-facing address/data only move for requests that reach memory
            if (accept && !bad) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_q;
    assign err_o        = err_q;
    assign rdata_o      = rdata_q;
    assign memRW_o      = (state_q == ISSUE) && store_q;
    assign dataSec_o    = (state_q == ISSUE) ? f3_q[1:0] : 2'b11;
    assign addr_o       = addr_q;
    assign dataW_o      = wdata_q;

endmodule

// File: tb/tb_lsu_port.sv
// Randomized bench for lsu_port: byte-array memory model on the memory side,
// byte-level reference model computing expected err/rdata/latency per request.
module tb_lsu_port;
    localparam int N = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0, is_store_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        req_ready_o, resp_valid_o, err_o, memRW_o;
    logic [31:0] rdata_o, addr_o, dataW_o;
    logic [1:0]  dataSec_o;
    logic [31:0] data_i = '0;

    int n_tests = 0, n_fail = 0;
    int wr_cyc = 0, iss_cyc = 0;
    logic [7:0] mem     [0:N];
    logic [7:0] ref_mem [0:N];

    lsu_port #(.N(N)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .resp_valid_o(resp_valid_o), .rdata_o(rdata_o), .err_o(err_o), .memRW_o(memRW_o),
        .dataSec_o(dataSec_o), .addr_o(addr_o), .dataW_o(dataW_o), .data_i(data_i)
    );

    always #5 clk = ~clk;

    // Memory: sized accesses, little-endian, read data registered and right-justified
    always @(posedge clk) begin
        int nb;
        logic [31:0] rd;
        if (dataSec_o != 2'b11) begin
            iss_cyc++;
            nb = (dataSec_o == 2'b00) ? 1 : (dataSec_o == 2'b01) ? 2 : 4;
            rd = '0;
            for (int i = 0; i < nb; i++) begin
                if (addr_o + i <= N) begin
                    if (memRW_o) mem[addr_o + i] = dataW_o[8*i +: 8];
                    else         rd[8*i +: 8] = mem[addr_o + i];
                end
            end
            if (memRW_o) wr_cyc++;
            else         data_i <= rd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output bit e_err,
                         output logic [31:0] e_rd, output int e_lat);
        int  size;
        bit  legal;
        longint v;
        size  = 1 << f3[1:0];
        legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e_err = !legal || (longint'(a) + size - 1 > N);
`ifdef LSU_ALIGN_CHECK_EN
        if (legal && (a % size) != 0) e_err = 1;
`endif
        if (e_err) begin
            e_rd = 0; e_lat = 1;
        end else if (st) begin
            for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
            e_rd = 0; e_lat = 2;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_mem[a + i]) << (8 * i);
            if (size < 4 && !f3[2] && v >= (64'd1 << (8 * size - 1)))
                v -= (64'd1 << (8 * size));
            e_rd = v[31:0]; e_lat = 3;
        end
    endtask

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag, output logic [31:0] rd_out);
        bit e_err;
        logic [31:0] e_rd, g_rd;
        int e_lat, lat, wr0, is0;
        logic g_err;
        model(st, f3, a, wd, e_err, e_rd, e_lat);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
        wr0 = wr_cyc; is0 = iss_cyc;
        @(posedge clk); #1;
        req_valid_i = 0; addr_i = $urandom; wdata_i = $urandom; funct3_i = 3'($urandom);
        lat = 0; g_err = 0; g_rd = 0;
        for (int j = 1; j <= 6 && lat == 0; j++) begin
            @(negedge clk);
            if (resp_valid_o) begin lat = j; g_err = err_o; g_rd = rdata_o; end
        end
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_err"}, 32'(g_err), 32'(e_err));
        chk({tag, "_rdata"}, g_rd, e_rd);
        chk({tag, "_writes"}, wr_cyc - wr0, (st && !e_err) ? 1 : 0);
        chk({tag, "_issues"}, iss_cyc - is0, e_err ? 0 : 1);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(resp_valid_o), 32'd0);
        chk({tag, "_hold"}, rdata_o, g_rd);
        rd_out = g_rd;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o), 1);
        chk({tag, "_resp"}, 32'(resp_valid_o), 0);
        chk({tag, "_err"}, 32'(err_o), 0);
        chk({tag, "_rdata"}, rdata_o, 0);
        chk({tag, "_memRW"}, 32'(memRW_o), 0);
        chk({tag, "_dataSec"}, 32'(dataSec_o), 3);
        chk({tag, "_addr"}, addr_o, 0);
        chk({tag, "_dataW"}, dataW_o, 0);
    endtask

    initial begin
        logic [31:0] r;
        int pulses;
        for (int i = 0; i <= N; i++) begin mem[i] = 0; ref_mem[i] = 0; end
        #12;
        chk_reset("reset");
        @(negedge clk); rst = 0;

        do_req(1, 3'b010, 4, 32'h80FF1234, "sw4", r);
        do_req(0, 3'b010, 4, 0, "lw4", r);   chk("lw4_const", r, 32'h80FF1234);
        do_req(0, 3'b000, 7, 0, "lb7", r);   chk("lb7_const", r, 32'hFFFFFF80);
        do_req(0, 3'b100, 7, 0, "lbu7", r);  chk("lbu7_const", r, 32'h00000080);
        do_req(0, 3'b001, 6, 0, "lh6", r);   chk("lh6_const", r, 32'hFFFF80FF);
        do_req(0, 3'b101, 4, 0, "lhu4", r);  chk("lhu4_const", r, 32'h00001234);
        do_req(0, 3'b010, 18, 0, "lw18_oob", r);
        chk("lw18_dataSec", 32'(dataSec_o), 3);
        do_req(0, 3'b010, 16, 0, "lw16_edge", r);
        do_req(1, 3'b000, 20, 32'hA5, "sb20_edge", r);
        do_req(0, 3'b100, 20, 0, "lbu20", r);
        do_req(0, 3'b000, 21, 0, "lb21_oob", r);
        do_req(0, 3'b001, 20, 0, "lh20_oob", r);
        do_req(0, 3'b010, 32'hFFFFFFFF, 0, "lw_wrap", r);
        do_req(0, 3'b011, 0, 0, "ld_illegal", r);
        do_req(1, 3'b100, 0, 32'h1, "st_illegal", r);
        do_req(0, 3'b010, 2, 0, "lw2_misal", r);
        do_req(1, 3'b001, 9, 32'hBEEF, "sh9_misal", r);

        // reset while a load sits in CAPT
        @(negedge clk);
        req_valid_i = 1; is_store_i = 0; funct3_i = 3'b010; addr_i = 4;
        @(posedge clk); #1 req_valid_i = 0;
        @(posedge clk); #2 rst = 1; #1;
        chk_reset("rst_capt");
        pulses = 0;
        for (int j = 0; j < 3; j++) begin @(negedge clk); if (resp_valid_o) pulses++; end
        rst = 0;
        for (int j = 0; j < 3; j++) begin @(negedge clk); if (resp_valid_o) pulses++; end
        chk("rst_capt_no_pulse", pulses, 0);
        do_req(0, 3'b010, 4, 0, "after_rst", r);

        // reset while a store is in ISSUE: write strobe drops without a clock
        @(negedge clk);
        req_valid_i = 1; is_store_i = 1; funct3_i = 3'b010; addr_i = 8; wdata_i = 32'hDEADBEEF;
        @(posedge clk); #1 req_valid_i = 0;
        chk("st_issue_memRW", 32'(memRW_o), 1);
        rst = 1; #1;
        chk("st_abort_memRW", 32'(memRW_o), 0);
        @(negedge clk); rst = 0;
        do_req(0, 3'b010, 8, 0, "abort_not_written", r);

        for (int t = 0; t < 150; t++) begin
            bit st;
            logic [2:0] f3;
            st = 1'($urandom);
            f3 = 3'($urandom);
            do_req(st, f3, $urandom_range(0, N + 3), $urandom, "rand", r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
